// File: rtl/jedro_1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jedro_1_pkg
// Description : Shared widths, register-index constants and the writeback
//               source enumeration for the jedro_1 writeback slice.
// Revision    : 1.0 - initial release
// ============================================================================
package jedro_1_pkg;

    localparam int unsigned JEDRO_1_DATA_WIDTH = 32;
    localparam int unsigned JEDRO_1_ADDR_WIDTH = $clog2(JEDRO_1_DATA_WIDTH);
    localparam int unsigned REG_X0             = 0;

    typedef enum logic [0:0] {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage : jedro_1_pkg
`default_nettype wire

// File: rtl/jedro_1_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : jedro_1_scoreboard
// Description : Per-register pending bits with set-over-clear priority, two
//               busy lookup ports and a sticky unsolicited-write error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module jedro_1_scoreboard
    import jedro_1_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = JEDRO_1_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  set_i,
    input  logic [ADDR_WIDTH-1:0] set_addr_i,
    input  logic                  clr_i,
    input  logic [ADDR_WIDTH-1:0] clr_addr_i,
    input  logic [ADDR_WIDTH-1:0] rpb_addr_i,
    input  logic [ADDR_WIDTH-1:0] rpc_addr_i,
    output logic                  rpb_pending_o,
    output logic                  rpc_pending_o,
    output logic                  sb_err_o
);

    localparam int unsigned NUM_REGISTERS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_X0 = ADDR_WIDTH'(REG_X0);

    logic [NUM_REGISTERS-1:0] r_pending;
    logic [NUM_REGISTERS-1:0] w_pending_nxt;
    logic                     r_sb_err;
    logic                     w_err_hit;

    // Clear first, then set: a new producer issued on the commit edge wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (clr_i) begin
            w_pending_nxt[clr_addr_i] = 1'b0;
        end
        if (set_i && (set_addr_i != C_X0)) begin
            w_pending_nxt[set_addr_i] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    assign w_err_hit = clr_i && !r_pending[clr_addr_i];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pending <= '0;
            r_sb_err  <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_sb_err  <= r_sb_err | w_err_hit;
        end
    end

    assign rpb_pending_o = r_pending[rpb_addr_i];
    assign rpc_pending_o = r_pending[rpc_addr_i];
    assign sb_err_o      = r_sb_err;

endmodule : jedro_1_scoreboard
`default_nettype wire

// File: rtl/jedro_1_writeback.sv
`default_nettype none
// ============================================================================
// Module      : jedro_1_writeback
// Description : Writeback stage: LSU-over-ALU arbitration onto the register
//               file write port, registered one cycle, plus pending scoreboard.
//               Optional result bypass enabled by macro JEDRO_1_WB_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module jedro_1_writeback
    import jedro_1_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = JEDRO_1_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [ADDR_WIDTH-1:0] alu_rd_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    input  logic                  sb_set_i,
    input  logic [ADDR_WIDTH-1:0] sb_set_addr_i,
    input  logic [ADDR_WIDTH-1:0] rpb_addr_i,
    input  logic [ADDR_WIDTH-1:0] rpc_addr_i,
    output logic                  rpb_busy_o,
    output logic                  rpc_busy_o,
    output logic                  rpb_fwd_valid_o,
    output logic                  rpc_fwd_valid_o,
    output logic [DATA_WIDTH-1:0] rpb_fwd_data_o,
    output logic [DATA_WIDTH-1:0] rpc_fwd_data_o,
    output logic [ADDR_WIDTH-1:0] wpa_addr_o,
    output logic [DATA_WIDTH-1:0] wpa_data_o,
    output logic                  wpa_we_o,
    output logic                  sb_err_o
);

    localparam logic [ADDR_WIDTH-1:0] C_X0 = ADDR_WIDTH'(REG_X0);

    wb_src_e               w_src;
    logic                  w_fire;
    logic [ADDR_WIDTH-1:0] w_rd;
    logic [DATA_WIDTH-1:0] w_data;

    logic                  r_wpa_we;
    logic [ADDR_WIDTH-1:0] r_wpa_addr;
    logic [DATA_WIDTH-1:0] r_wpa_data;

    logic                  w_rpb_pending;
    logic                  w_rpc_pending;

    // LSU always wins; ALU readiness depends only on the LSU request.
    assign lsu_ready_o = 1'b1;
    assign alu_ready_o = !lsu_valid_i;

    always_comb begin
        w_fire = lsu_valid_i || alu_valid_i;
        w_src  = lsu_valid_i ? WB_SRC_LSU : WB_SRC_ALU;
        w_rd   = alu_rd_i;
        w_data = alu_data_i;
        if (w_src == WB_SRC_LSU) begin
            w_rd   = lsu_rd_i;
            w_data = lsu_data_i;
        end
    end

    // Results for x0 complete the handshake but never raise the write enable.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wpa_we   <= 1'b0;
            r_wpa_addr <= '0;
            r_wpa_data <= '0;
        end else begin
            r_wpa_we <= w_fire && (w_rd != C_X0);
            if (w_fire) begin
                r_wpa_addr <= w_rd;
                r_wpa_data <= w_data;
            end
        end
    end

    assign wpa_we_o   = r_wpa_we;
    assign wpa_addr_o = r_wpa_addr;
    assign wpa_data_o = r_wpa_data;

    jedro_1_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .set_i         (sb_set_i),
        .set_addr_i    (sb_set_addr_i),
        .clr_i         (r_wpa_we),
        .clr_addr_i    (r_wpa_addr),
        .rpb_addr_i    (rpb_addr_i),
        .rpc_addr_i    (rpc_addr_i),
        .rpb_pending_o (w_rpb_pending),
        .rpc_pending_o (w_rpc_pending),
        .sb_err_o      (sb_err_o)
    );

`ifdef JEDRO_1_WB_FWD_EN
    // The in-flight write is visible one cycle before the register file has it.
    assign rpb_fwd_valid_o = r_wpa_we && (r_wpa_addr == rpb_addr_i) && (rpb_addr_i != C_X0);
    assign rpc_fwd_valid_o = r_wpa_we && (r_wpa_addr == rpc_addr_i) && (rpc_addr_i != C_X0);
    assign rpb_fwd_data_o  = r_wpa_data;
    assign rpc_fwd_data_o  = r_wpa_data;
`else
    assign rpb_fwd_valid_o = 1'b0;
    assign rpc_fwd_valid_o = 1'b0;
    assign rpb_fwd_data_o  = '0;
    assign rpc_fwd_data_o  = '0;
`endif

    assign rpb_busy_o = w_rpb_pending && !rpb_fwd_valid_o;
    assign rpc_busy_o = w_rpc_pending && !rpc_fwd_valid_o;

endmodule : jedro_1_writeback
`default_nettype wire

// File: tb/tb_jedro_1_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_jedro_1_writeback
// Description : Scoreboard bench for jedro_1_writeback: directed scenarios
//               followed by constrained-random traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jedro_1_writeback;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
`ifdef JEDRO_1_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          alu_valid_i, lsu_valid_i, sb_set_i;
    logic [AW-1:0] alu_rd_i, lsu_rd_i, sb_set_addr_i, rpb_addr_i, rpc_addr_i;
    logic [DW-1:0] alu_data_i, lsu_data_i;
    logic          alu_ready_o, lsu_ready_o, rpb_busy_o, rpc_busy_o;
    logic          rpb_fwd_valid_o, rpc_fwd_valid_o, wpa_we_o, sb_err_o;
    logic [DW-1:0] rpb_fwd_data_o, rpc_fwd_data_o, wpa_data_o;
    logic [AW-1:0] wpa_addr_o;

    always #5 clk_i = ~clk_i;

    jedro_1_writeback dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .alu_valid_i     (alu_valid_i),
        .alu_ready_o     (alu_ready_o),
        .alu_rd_i        (alu_rd_i),
        .alu_data_i      (alu_data_i),
        .lsu_valid_i     (lsu_valid_i),
        .lsu_ready_o     (lsu_ready_o),
        .lsu_rd_i        (lsu_rd_i),
        .lsu_data_i      (lsu_data_i),
        .sb_set_i        (sb_set_i),
        .sb_set_addr_i   (sb_set_addr_i),
        .rpb_addr_i      (rpb_addr_i),
        .rpc_addr_i      (rpc_addr_i),
        .rpb_busy_o      (rpb_busy_o),
        .rpc_busy_o      (rpc_busy_o),
        .rpb_fwd_valid_o (rpb_fwd_valid_o),
        .rpc_fwd_valid_o (rpc_fwd_valid_o),
        .rpb_fwd_data_o  (rpb_fwd_data_o),
        .rpc_fwd_data_o  (rpc_fwd_data_o),
        .wpa_addr_o      (wpa_addr_o),
        .wpa_data_o      (wpa_data_o),
        .wpa_we_o        (wpa_we_o),
        .sb_err_o        (sb_err_o)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    // Reference model: expected commits, pending set, sticky error, in-flight write.
    wr_t           exp_q[$];
    wr_t           mon_e;
    bit            m_pend[NR];
    bit            m_err;
    bit            m_inf_v;
    logic [AW-1:0] m_inf_a;
    logic [DW-1:0] m_last_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_err    = 1'b0;
        m_inf_v  = 1'b0;
        m_inf_a  = '0;
        m_last_d = '0;
        exp_q.delete();
    endtask

    task automatic accept(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        m_last_d = d;
        if (rd != 0) begin
            m_inf_v = 1'b1;
            m_inf_a = rd;
            exp_q.push_back('{a: rd, d: d});
        end
    endtask

    // Advance one clock and apply the architectural rules to the sampled inputs.
    task automatic step();
        @(posedge clk_i);
        #1;
        if (rstn_i) begin
            if (m_inf_v) begin
                if (!m_pend[m_inf_a]) m_err = 1'b1;
                m_pend[m_inf_a] = 1'b0;
            end
            if (sb_set_i && sb_set_addr_i != 0) m_pend[sb_set_addr_i] = 1'b1;
            m_inf_v = 1'b0;
            if (lsu_valid_i)      accept(lsu_rd_i, lsu_data_i);
            else if (alu_valid_i) accept(alu_rd_i, alu_data_i);
        end
    endtask

    task automatic drv(input bit av, input int ard, input logic [DW-1:0] ad,
                       input bit lv, input int lrd, input logic [DW-1:0] ld,
                       input bit s, input int sa, input int pb, input int pc);
        alu_valid_i = av;  alu_rd_i = AW'(ard);  alu_data_i = ad;
        lsu_valid_i = lv;  lsu_rd_i = AW'(lrd);  lsu_data_i = ld;
        sb_set_i = s;      sb_set_addr_i = AW'(sa);
        rpb_addr_i = AW'(pb);
        rpc_addr_i = AW'(pc);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},      32'(wpa_we_o), 0);
        chk({tag, "_addr"},    32'(wpa_addr_o), 0);
        chk({tag, "_data"},    wpa_data_o, 0);
        chk({tag, "_err"},     32'(sb_err_o), 0);
        chk({tag, "_busy_b"},  32'(rpb_busy_o), 0);
        chk({tag, "_busy_c"},  32'(rpc_busy_o), 0);
        chk({tag, "_fwdv_b"},  32'(rpb_fwd_valid_o), 0);
        chk({tag, "_fwdv_c"},  32'(rpc_fwd_valid_o), 0);
        chk({tag, "_fwdd_b"},  rpb_fwd_data_o, 0);
        chk({tag, "_fwdd_c"},  rpc_fwd_data_o, 0);
    endtask

    // Monitor: compares every cycle, popping an expected commit whenever the DUT writes.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            chk("lsu_ready", 32'(lsu_ready_o), 1);
            chk("alu_ready", 32'(alu_ready_o), 32'(!lsu_valid_i));
            chk("wpa_we", 32'(wpa_we_o), 32'(m_inf_v));
            if (wpa_we_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(wpa_addr_o), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wpa_addr", 32'(wpa_addr_o), 32'(mon_e.a));
                    chk("wpa_data", wpa_data_o, mon_e.d);
                end
            end
            chk("sb_err", 32'(sb_err_o), 32'(m_err));
            begin
                bit hb, hc;
                hb = FWD && m_inf_v && (m_inf_a == rpb_addr_i) && (rpb_addr_i != 0);
                hc = FWD && m_inf_v && (m_inf_a == rpc_addr_i) && (rpc_addr_i != 0);
                chk("rpb_busy", 32'(rpb_busy_o), 32'(m_pend[rpb_addr_i] && !hb));
                chk("rpc_busy", 32'(rpc_busy_o), 32'(m_pend[rpc_addr_i] && !hc));
                chk("rpb_fwd_valid", 32'(rpb_fwd_valid_o), 32'(hb));
                chk("rpc_fwd_valid", 32'(rpc_fwd_valid_o), 32'(hc));
                chk("rpb_fwd_data", rpb_fwd_data_o, FWD ? m_last_d : 32'h0);
                chk("rpc_fwd_data", rpc_fwd_data_o, FWD ? m_last_d : 32'h0);
            end
        end
    end

    initial begin
        model_reset();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstn_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3;
        check_reset_outputs("reset");
        @(negedge clk_i);
        #2 rstn_i = 1'b1;

        // Single ALU write to a pending x5
        drv(0, 0, 0, 0, 0, 0, 1, 5, 5, 5);                 step();
        drv(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5);      step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);                 step(); step();

        // LSU/ALU contention: ALU held until granted
        drv(0, 0, 0, 0, 0, 0, 1, 3, 3, 4);                 step();
        drv(0, 0, 0, 0, 0, 0, 1, 4, 3, 4);                 step();
        drv(1, 4, 32'h22, 1, 3, 32'h11, 0, 0, 3, 4);       step();
        drv(1, 4, 32'h22, 0, 0, 0, 0, 0, 3, 4);            step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);                 step(); step();

        // Result for x0 is consumed and discarded
        drv(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);      step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                 step(); step();

        // Set and clear of x7 on the same edge: x7 stays pending
        drv(0, 0, 0, 0, 0, 0, 1, 7, 7, 7);                 step();
        drv(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 7);            step();
        drv(0, 0, 0, 0, 0, 0, 1, 7, 7, 7);                 step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);                 step(); step();

        // Unsolicited write to x9 raises the sticky error
        drv(1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 9);            step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);                 step(); step(); step();

        // In-flight write of x5 visible on the rpc port
        drv(0, 0, 0, 0, 0, 0, 1, 5, 0, 5);                 step();
        drv(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 5);          step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 5);                 step(); step();

        // Asynchronous reset mid-cycle while a write is on the port
        drv(0, 0, 0, 0, 0, 0, 1, 6, 6, 6);                 step();
        drv(1, 6, 32'h55, 0, 0, 0, 0, 0, 6, 6);            step();
        #2;
        chk("pre_reset_we", 32'(wpa_we_o), 1);
        rstn_i = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 6, 6);
        @(negedge clk_i);
        #2 rstn_i = 1'b1;
        step();

        // Random traffic; a blocked ALU result is held stable until granted
        for (int n = 0; n < 3000; n++) begin
            bit blk;
            blk = alu_valid_i && lsu_valid_i;
            if (!blk) begin
                alu_valid_i = ($urandom_range(0, 2) != 0);
                alu_rd_i    = AW'($urandom_range(0, 9));
                alu_data_i  = $urandom;
            end
            lsu_valid_i   = ($urandom_range(0, 3) == 0);
            lsu_rd_i      = AW'($urandom_range(0, 9));
            lsu_data_i    = $urandom;
            sb_set_i      = ($urandom_range(0, 1) == 1);
            sb_set_addr_i = AW'($urandom_range(0, 9));
            rpb_addr_i    = AW'($urandom_range(0, 9));
            rpc_addr_i    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 9));
            step();
        end

        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); step(); step();
        @(negedge clk_i);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_jedro_1_writeback
`default_nettype wire
